// File: rtl/i2s_clock_sequencer.sv
// Serial-audio timing controller: bclk, lrclk and frame/edge strobes from one clock.
// Divisor and slot length live in shadow registers and only change on frame boundaries.
module i2s_clock_sequencer #(
   parameter int DIV_W    = 8,
   parameter int SLOT_W   = 6,
   parameter int DEF_DIV  = 4,
   parameter int DEF_SLOT = 32
) (
   input  logic              clkIn,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              cfg_valid,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [SLOT_W-1:0] cfg_slot,
   output logic              cfg_ready,
   output logic              cfg_err,
   output logic              bclk_out,
   output logic              bclk_rise,
   output logic              bclk_fall,
   output logic              lrclk_out,
   output logic              frame_start,
   output logic              busy
);

   localparam int CNT_W = SLOT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
   logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [DIV_W-1:0]  act_div_reg, act_div_next;
   logic [SLOT_W-1:0] act_slot_reg, act_slot_next;
   logic [DIV_W-1:0]  pend_div_reg, pend_div_next;
   logic [SLOT_W-1:0] pend_slot_reg, pend_slot_next;
   logic              pend_vld_reg, pend_vld_next;
   logic              cfg_ready_reg, cfg_ready_next;
   logic              cfg_err_reg, cfg_err_next;
   logic              bclk_reg, bclk_next;
   logic              rise_reg, rise_next;
   logic              fall_reg, fall_next;
   logic              lrclk_reg, lrclk_next;
   logic              fs_reg, fs_next;
   logic              busy_reg, busy_next;

   logic              boundary;
   logic [DIV_W-1:0]  div_last;
   logic [CNT_W-1:0]  bit_last;
   logic [CNT_W-1:0]  half_last;
   logic              cfg_offer;
   logic              cfg_bad;
   logic              cfg_accept;
   logic              cfg_apply;

   // Terminal counts derived from the active (never mid-frame updated) configuration.
   assign div_last  = act_div_reg - 1'b1;
   assign bit_last  = {act_slot_reg, 1'b0} - 1'b1;
   assign half_last = {1'b0, act_slot_reg} - 1'b1;

   // Timing generator and run/drain control.
   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg;
      bit_cnt_next = bit_cnt_reg;
      bclk_next    = bclk_reg;
      lrclk_next   = lrclk_reg;
      rise_next    = 1'b0;
      fall_next    = 1'b0;
      fs_next      = 1'b0;
      boundary     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            div_cnt_next = '0;
            bit_cnt_next = '0;
            bclk_next    = 1'b0;
            lrclk_next   = 1'b0;
            if (start && !stop) begin
               state_next = ST_RUN;
               fs_next    = 1'b1;
            end
         end
         ST_RUN, ST_DRAIN: begin
            if (state_reg == ST_RUN && stop) begin
               state_next = ST_DRAIN;
            end
            if (state_reg == ST_DRAIN && start) begin
               state_next = ST_RUN;
            end
            if (div_cnt_reg == div_last) begin
               div_cnt_next = '0;
               bclk_next    = ~bclk_reg;
               if (!bclk_reg) begin
                  rise_next = 1'b1;
               end else begin
                  fall_next = 1'b1;
                  if (bit_cnt_reg == bit_last) begin
                     // End of frame: either begin the next one or halt if draining.
                     bit_cnt_next = '0;
                     lrclk_next   = 1'b0;
                     boundary     = 1'b1;
                     if (state_next == ST_DRAIN) begin
                        state_next = ST_IDLE;
                     end else begin
                        fs_next = 1'b1;
                     end
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 1'b1;
                     if (bit_cnt_reg == half_last) begin
                        lrclk_next = 1'b1;
                     end
                  end
               end
            end else begin
               div_cnt_next = div_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next   = ST_IDLE;
            div_cnt_next = '0;
            bit_cnt_next = '0;
            bclk_next    = 1'b0;
            lrclk_next   = 1'b0;
         end
      endcase

      busy_next = (state_next != ST_IDLE);
   end

   // Configuration handshake; ready implies the pending slot is empty, so accept and apply never collide.
   assign cfg_offer  = cfg_valid && cfg_ready_reg;
   assign cfg_bad    = (cfg_div == '0) || (cfg_slot == '0);
   assign cfg_accept = cfg_offer && !cfg_bad;
   assign cfg_apply  = pend_vld_reg && ((state_reg == ST_IDLE) || boundary);

   always_comb begin
      pend_vld_next  = pend_vld_reg;
      pend_div_next  = pend_div_reg;
      pend_slot_next = pend_slot_reg;
      act_div_next   = act_div_reg;
      act_slot_next  = act_slot_reg;
      cfg_err_next   = cfg_offer && cfg_bad;

      if (cfg_accept) begin
         pend_vld_next  = 1'b1;
         pend_div_next  = cfg_div;
         pend_slot_next = cfg_slot;
      end else if (cfg_apply) begin
         pend_vld_next = 1'b0;
         act_div_next  = pend_div_reg;
         act_slot_next = pend_slot_reg;
      end

      // Ready stays low through the apply cycle and returns the cycle after.
      cfg_ready_next = !(pend_vld_next || cfg_apply);
   end

   always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         div_cnt_reg   <= '0;
         bit_cnt_reg   <= '0;
         act_div_reg   <= DIV_W'(DEF_DIV);
         act_slot_reg  <= SLOT_W'(DEF_SLOT);
         pend_div_reg  <= '0;
         pend_slot_reg <= '0;
         pend_vld_reg  <= 1'b0;
         cfg_ready_reg <= 1'b1;
         cfg_err_reg   <= 1'b0;
         bclk_reg      <= 1'b0;
         rise_reg      <= 1'b0;
         fall_reg      <= 1'b0;
         lrclk_reg     <= 1'b0;
         fs_reg        <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         div_cnt_reg   <= div_cnt_next;
         bit_cnt_reg   <= bit_cnt_next;
         act_div_reg   <= act_div_next;
         act_slot_reg  <= act_slot_next;
         pend_div_reg  <= pend_div_next;
         pend_slot_reg <= pend_slot_next;
         pend_vld_reg  <= pend_vld_next;
         cfg_ready_reg <= cfg_ready_next;
         cfg_err_reg   <= cfg_err_next;
         bclk_reg      <= bclk_next;
         rise_reg      <= rise_next;
         fall_reg      <= fall_next;
         lrclk_reg     <= lrclk_next;
         fs_reg        <= fs_next;
         busy_reg      <= busy_next;
      end
   end

   assign cfg_ready   = cfg_ready_reg;
   assign cfg_err     = cfg_err_reg;
   assign bclk_out    = bclk_reg;
   assign bclk_rise   = rise_reg;
   assign bclk_fall   = fall_reg;
   assign lrclk_out   = lrclk_reg;
   assign frame_start = fs_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_i2s_clock_sequencer.sv
// Directed bench for i2s_clock_sequencer; outputs sampled on the falling clock edge.
module tb_i2s_clock_sequencer;

   logic       clkIn = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_div = '0;
   logic [5:0] cfg_slot = '0;
   logic       cfg_ready, cfg_err, bclk_out, bclk_rise, bclk_fall, lrclk_out, frame_start, busy;
   logic [5:0] obs;
   logic [5:0] exp_v;

   int checks = 0;
   int passes = 0;

   always #5 clkIn = ~clkIn;

   i2s_clock_sequencer dut (
      .clkIn(clkIn), .reset(reset), .start(start), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_slot(cfg_slot),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err), .bclk_out(bclk_out),
      .bclk_rise(bclk_rise), .bclk_fall(bclk_fall), .lrclk_out(lrclk_out),
      .frame_start(frame_start), .busy(busy)
   );

   // {busy, frame_start, bclk_out, bclk_rise, bclk_fall, lrclk_out}
   assign obs = {busy, frame_start, bclk_out, bclk_rise, bclk_fall, lrclk_out};

   // Ideal waveform for a run with fixed D,S, c cycles after the run's first cycle.
   function automatic logic [5:0] model(int d, int s, int c, bit first);
      int f;
      int fc;
      int p;
      f  = 4 * d * s;
      fc = c % f;
      p  = fc % (2 * d);
      model = {1'b1, fc == 0, p >= d, p == d, (p == 0) && !(first && c == 0), fc >= 2 * d * s};
   endfunction

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
      repeat (2) @(negedge clkIn);
      reset = 1'b0;
   endtask

   task automatic load_cfg(input int d, input int s);
      @(negedge clkIn);
      cfg_valid = 1'b1; cfg_div = 8'(d); cfg_slot = 6'(s);
      @(negedge clkIn);
      cfg_valid = 1'b0;
      repeat (3) @(negedge clkIn);
   endtask

   // Leaves the bench at the falling edge of run cycle 0.
   task automatic start_run();
      @(negedge clkIn);
      start = 1'b1;
      @(negedge clkIn);
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clkIn);
      checks++;
      if (obs !== 6'b0) $display("FAIL reset_outputs: got %b expected %b", obs, 6'b0);
      else passes++;
      checks++;
      if (cfg_ready !== 1'b1 || cfg_err !== 1'b0)
         $display("FAIL reset_cfg: got ready=%b err=%b expected ready=1 err=0", cfg_ready, cfg_err);
      else passes++;
      reset = 1'b0;
   endtask

   task automatic test_basic_d2s2();
      @(negedge clkIn);
      cfg_valid = 1'b1; cfg_div = 8'd2; cfg_slot = 6'd2;
      @(negedge clkIn);
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) $display("FAIL idle_cfg_ready_drop: got %b expected 0", cfg_ready);
      else passes++;
      repeat (2) @(negedge clkIn);
      checks++;
      if (cfg_ready !== 1'b1) $display("FAIL idle_cfg_ready_return: got %b expected 1", cfg_ready);
      else passes++;
      start_run();
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clkIn);
         exp_v = model(2, 2, c, 1'b1);
         checks++;
         if (obs !== exp_v) $display("FAIL d2s2 cycle %0d: got %b expected %b", c, obs, exp_v);
         else passes++;
      end
      do_reset();
   endtask

   task automatic test_d1s1();
      load_cfg(1, 1);
      start_run();
      for (int c = 0; c < 14; c++) begin
         if (c > 0) @(negedge clkIn);
         exp_v = model(1, 1, c, 1'b1);
         checks++;
         if (obs !== exp_v) $display("FAIL d1s1 cycle %0d: got %b expected %b", c, obs, exp_v);
         else passes++;
      end
      do_reset();
   endtask

   task automatic test_cfg_change_running();
      logic exp_rdy;
      load_cfg(2, 2);
      start_run();
      for (int c = 0; c < 42; c++) begin
         if (c > 0) @(negedge clkIn);
         exp_v   = (c < 16) ? model(2, 2, c, 1'b1) : model(3, 1, c - 16, 1'b0);
         exp_rdy = !(c >= 6 && c <= 16);
         checks++;
         if (obs !== exp_v) $display("FAIL cfg_change cycle %0d: got %b expected %b", c, obs, exp_v);
         else passes++;
         checks++;
         if (cfg_ready !== exp_rdy)
            $display("FAIL cfg_change_ready cycle %0d: got %b expected %b", c, cfg_ready, exp_rdy);
         else passes++;
         if (c == 5) begin
            cfg_valid = 1'b1; cfg_div = 8'd3; cfg_slot = 6'd1;
         end else begin
            cfg_valid = 1'b0;
         end
      end
      do_reset();
   endtask

   task automatic test_cfg_err();
      logic exp_err;
      load_cfg(2, 2);
      start_run();
      for (int c = 0; c < 36; c++) begin
         if (c > 0) @(negedge clkIn);
         exp_v   = model(2, 2, c, 1'b1);
         exp_err = (c == 4 || c == 8);
         checks++;
         if (obs !== exp_v) $display("FAIL cfg_err_timing cycle %0d: got %b expected %b", c, obs, exp_v);
         else passes++;
         checks++;
         if (cfg_err !== exp_err || cfg_ready !== 1'b1)
            $display("FAIL cfg_err cycle %0d: got err=%b ready=%b expected err=%b ready=1",
                     c, cfg_err, cfg_ready, exp_err);
         else passes++;
         cfg_valid = 1'b0;
         if (c == 3) begin
            cfg_valid = 1'b1; cfg_div = 8'd0; cfg_slot = 6'd5;
         end
         if (c == 7) begin
            cfg_valid = 1'b1; cfg_div = 8'd5; cfg_slot = 6'd0;
         end
      end
      do_reset();
   endtask

   task automatic test_stop_and_restart();
      load_cfg(2, 2);
      start_run();
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clkIn);
         if (c < 16) exp_v = model(2, 2, c, 1'b1);
         else if (c == 16) exp_v = 6'b000010;
         else exp_v = 6'b000000;
         checks++;
         if (obs !== exp_v) $display("FAIL stop_drain cycle %0d: got %b expected %b", c, obs, exp_v);
         else passes++;
         stop = (c == 3);
      end
      start_run();
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clkIn);
         exp_v = model(2, 2, c, 1'b1);
         checks++;
         if (obs !== exp_v) $display("FAIL drain_restart cycle %0d: got %b expected %b", c, obs, exp_v);
         else passes++;
         stop  = (c == 3);
         start = (c == 10);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_frame();
      load_cfg(2, 2);
      start_run();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clkIn);
         exp_v = model(2, 2, c, 1'b1);
         checks++;
         if (obs !== exp_v) $display("FAIL pre_reset cycle %0d: got %b expected %b", c, obs, exp_v);
         else passes++;
         cfg_valid = (c == 5);
         cfg_div   = 8'd7;
         cfg_slot  = 6'd3;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== 6'b0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0)
         $display("FAIL async_reset: got %b ready=%b err=%b expected 000000 ready=1 err=0",
                  obs, cfg_ready, cfg_err);
      else passes++;
      #1;
      reset = 1'b0;
      start_run();
      for (int c = 0; c < 520; c++) begin
         if (c > 0) @(negedge clkIn);
         exp_v = model(4, 32, c, 1'b1);
         checks++;
         if (obs !== exp_v) $display("FAIL default_cfg cycle %0d: got %b expected %b", c, obs, exp_v);
         else passes++;
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_basic_d2s2();
      test_d1s1();
      test_cfg_change_running();
      test_cfg_err();
      test_stop_and_restart();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
